// File: rtl/id_stage_pkg.sv
// Shared decode constants for the id_stage slice: opcodes, ALU funct3 codes,
// instruction field positions and the RUN/HALT state encoding.
package id_stage_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    // Same encodings the ALU decodes
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam int OPC_LSB = 0;
    localparam int RD_LSB  = 7;
    localparam int F3_LSB  = 12;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int IMM_LSB = 20;
    localparam int MOD_BIT = 30;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        mod;
        logic [11:0] imm;
    } instr_f_t;

    function automatic instr_f_t split_instr(input logic [31:0] i);
        instr_f_t f;
        f.opcode = i[OPC_LSB +: 7];
        f.rd     = i[RD_LSB +: 5];
        f.funct3 = i[F3_LSB +: 3];
        f.rs1    = i[RS1_LSB +: 5];
        f.rs2    = i[RS2_LSB +: 5];
        f.mod    = i[MOD_BIT];
        f.imm    = i[IMM_LSB +: 12];
        return f;
    endfunction

endpackage

// File: rtl/id_regfile.sv
// Operand register file: two combinational read ports with writeback bypass,
// one write port, register 0 hardwired to zero.
module id_regfile #(
    parameter int M_WIDTH   = 8,
    parameter int NUM_REGS  = 16,
    parameter int REG_IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REG_IDX_W-1:0] ra1,
    input  logic [REG_IDX_W-1:0] ra2,
    output logic [M_WIDTH-1:0]   rd1,
    output logic [M_WIDTH-1:0]   rd2,
    input  logic                 wen,
    input  logic [REG_IDX_W-1:0] wa,
    input  logic [M_WIDTH-1:0]   wd
);

    logic [NUM_REGS-1:0][M_WIDTH-1:0] regs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            regs <= '0;
        else if (wen && wa != '0)
            regs[wa] <= wd;
    end

    always_comb begin
        rd1 = regs[ra1];
        if (ra1 == '0)
            rd1 = '0;
        else if (wen && wa == ra1)
            rd1 = wd;
    end

    always_comb begin
        rd2 = regs[ra2];
        if (ra2 == '0)
            rd2 = '0;
        else if (wen && wa == ra2)
            rd2 = wd;
    end

endmodule

// File: rtl/id_stage.sv
// Decode/operand-fetch stage feeding the ALU: OP/OP-IMM decode, busy
// scoreboard with writeback clear, registered ALU request, halt on illegal.
module id_stage
    import id_stage_pkg::*;
#(
    parameter int M_WIDTH   = 8,
    parameter int NUM_REGS  = 16,
    parameter int REG_IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [31:0]          instr,
    output logic                 ex_valid,
    input  logic                 ex_ready,
    output logic [2:0]           ex_funct3,
    output logic                 ex_modifier,
    output logic [M_WIDTH-1:0]   ex_in1,
    output logic [M_WIDTH-1:0]   ex_in2,
    output logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 wb_en,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic [M_WIDTH-1:0]   wb_data,
    output logic                 illegal
);

    instr_f_t               f;
    logic [REG_IDX_W-1:0]   rs1, rs2, rd;
    logic                   is_op, is_imm, legal, is_shift;
    logic [M_WIDTH-1:0]     op1, op2, in2_nxt;
    logic                   mod_nxt;
    logic [31:0]            simm, shamt;
    logic [NUM_REGS-1:0]    busy, busy_nxt;
    logic [0:0]             state;
    logic                   rs1_busy, rs2_busy, rd_busy, hazard;
    logic                   xfer, issue, bad;
    logic                   unused_hi;

    assign f         = split_instr(instr);
    assign rs1       = f.rs1[REG_IDX_W-1:0];
    assign rs2       = f.rs2[REG_IDX_W-1:0];
    assign rd        = f.rd[REG_IDX_W-1:0];
    assign unused_hi = ^{f.rd, f.rs1, f.rs2};

    assign is_op    = (f.opcode == OPC_OP);
    assign is_imm   = (f.opcode == OPC_OP_IMM);
    assign legal    = is_op || is_imm;
    assign is_shift = (f.funct3 == F3_SLL) || (f.funct3 == F3_SR);

    id_regfile #(
        .M_WIDTH   (M_WIDTH),
        .NUM_REGS  (NUM_REGS),
        .REG_IDX_W (REG_IDX_W)
    ) u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .ra1   (rs1),
        .ra2   (rs2),
        .rd1   (op1),
        .rd2   (op2),
        .wen   (wb_en),
        .wa    (wb_rd),
        .wd    (wb_data)
    );

    // A register retiring this cycle is already readable through the bypass
    assign rs1_busy = busy[rs1] && !(wb_en && wb_rd == rs1);
    assign rs2_busy = is_op && busy[rs2] && !(wb_en && wb_rd == rs2);
    assign rd_busy  = (rd != '0) && busy[rd] && !(wb_en && wb_rd == rd);
    assign hazard   = instr_valid && legal && (rs1_busy || rs2_busy || rd_busy);

    assign instr_ready = (state == ST_RUN) && (!ex_valid || ex_ready) && !hazard;
    assign xfer        = instr_valid && instr_ready;
    assign issue       = xfer && legal;
    assign bad         = xfer && !legal;
    assign illegal     = (state == ST_HALT);

    assign simm  = {{20{f.imm[11]}}, f.imm};
    assign shamt = {27'd0, f.rs2};

    always_comb begin
        mod_nxt = 1'b0;
        in2_nxt = op2;
        if (is_op) begin
            mod_nxt = f.mod && (f.funct3 == F3_ADD || f.funct3 == F3_SR);
        end else begin
            mod_nxt = f.mod && (f.funct3 == F3_SR);
            in2_nxt = is_shift ? shamt[M_WIDTH-1:0] : simm[M_WIDTH-1:0];
        end
    end

    // Set after clear so an issue to the register being retired keeps it busy
    always_comb begin
        busy_nxt = busy;
        if (wb_en && wb_rd != '0)
            busy_nxt[wb_rd] = 1'b0;
        if (issue && rd != '0)
            busy_nxt[rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= '0;
            state <= ST_RUN;
        end else begin
            busy <= busy_nxt;
            if (bad)
                state <= ST_HALT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_funct3   <= '0;
            ex_modifier <= 1'b0;
            ex_in1      <= '0;
            ex_in2      <= '0;
            ex_rd       <= '0;
        end else if (issue) begin
            ex_valid    <= 1'b1;
            ex_funct3   <= f.funct3;
            ex_modifier <= mod_nxt;
            ex_in1      <= op1;
            ex_in2      <= in2_nxt;
            ex_rd       <= rd;
        end else if (ex_ready) begin
            ex_valid    <= 1'b0;
        end
    end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode/operand-fetch stage that sits directly upstream of the core's ALU. It accepts RV32I-format instructions from fetch and reads operands from an internal register file.
- It produces a registered ALU request: funct3, modifier, in1, in2, and a destination tag for writeback.
- A per-register busy scoreboard stalls dependent instructions. The writeback port from the downstream stage writes the register file and clears busy bits.
- OP and OP-IMM opcodes only. Any other opcode halts the stage.

Parameters:
- M_WIDTH, 8, datapath/register width.
- NUM_REGS, 16, register count; register 0 reads as zero and is never written or marked busy.
- REG_IDX_W, 4, register index width, equal to clog2(NUM_REGS).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- instr_valid  input  1  fetch presents an instruction.
- instr_ready  output  1  stage accepts the instruction this cycle.
- instr  input  32  RV32I-encoded instruction.
- ex_valid  output  1  ALU request is valid.
- ex_ready  input  1  downstream consumes the request.
- ex_funct3  output  3  ALU operation select.
- ex_modifier  output  1  ALU modifier: SUB or arithmetic shift.
- ex_in1  output  M_WIDTH  operand 1, from rs1.
- ex_in2  output  M_WIDTH  operand 2, from rs2 or the immediate.
- ex_rd  output  REG_IDX_W  destination register.
- wb_en  input  1  writeback strobe.
- wb_rd  input  REG_IDX_W  writeback destination.
- wb_data  input  M_WIDTH  writeback value.
- illegal  output  1  sticky: an illegal instruction was seen; stage halted.

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: ex_valid=0, ex_funct3=0, ex_modifier=0, ex_in1=0, ex_in2=0, ex_rd=0, illegal=0.
  - State: all registers=0, scoreboard=0, FSM=RUN.
  - Assertion of rst_n=0 mid-transfer drops any pending request.
- FSM states:
  - RUN: normal operation.
  - HALT: entered on the clock edge after an illegal instruction is accepted. illegal=1, instr_ready=0. A request already in the ex_* register still drains normally. Exit from HALT only by reset.
- Decode:
  - opcode 0110011 (OP): in2 = reg[rs2]. modifier = instr[30] only when funct3 is ADD(000) or SR(101), else 0.
  - opcode 0010011 (OP-IMM): in2 = the low M_WIDTH bits of sign-extended instr[31:20]. modifier = instr[30] only when funct3=101, else 0. For shifts, in2 = the low M_WIDTH bits of zero-extended instr[24:20].
  - Any other opcode is illegal. It is accepted, never issued, and moves the FSM to HALT.
- Operand read:
  - Register 0 reads as 0.
  - Bypass: if wb_en=1 and wb_rd equals the source register (nonzero), the operand is wb_data in the same cycle.
- Hazard (combinational, evaluated when instr_valid=1):
  - Stall if rs1 is busy, or rs2 is busy (OP only), or rd is busy (WAW).
  - A register being written back this cycle (wb_en=1 and wb_rd matches) counts as not busy.
  - rd=0 never stalls.
- Handshake:
  - instr_ready = RUN && (!ex_valid || ex_ready) && !hazard. instr_ready may depend on instr_valid and instr.
  - Transfer occurs when instr_valid && instr_ready. The ex_* registers load on the next edge and ex_valid becomes 1.
  - If ex_valid && ex_ready and there is no new transfer, ex_valid becomes 0.
  - While ex_valid=1 and ex_ready=0, all ex_* outputs hold stable.
  - Latency: exactly 1 cycle from accept to ex_valid.
- Scoreboard:
  - On issue with rd≠0, set busy[rd].
  - On wb_en with wb_rd≠0, write the register and clear busy[wb_rd].
  - If the same register is set and cleared in the same cycle, set wins.
- Writes:
  - A write to register 0 is ignored.
  - Writeback is accepted in any state, including HALT.

Decomposition:
- Shared package holds:
  - opcode constants OPC_OP and OPC_OP_IMM.
  - F3_* funct3 encodings, identical values to the ALU's.
  - Instruction field bit positions.
  - RUN/HALT state encoding.
- One sub-module: id_regfile.
  - NUM_REGS x M_WIDTH registers.
  - Two combinational read ports with writeback bypass.
  - One write port, register 0 hardwired to zero.
  - Async active-low reset.

Test Plan:
1. Write x1=5 via writeback. Send add x3,x1,x2 (0x002081B3) with x2=3 written. Expect:
   - one cycle later, ex_funct3=000, ex_modifier=0, ex_in1=5, ex_in2=3, ex_rd=3.
   - busy[3]=1.
2. Send sub x3,x1,x2 (0x402081B3) with x1=5, x2=3 -> ex_modifier=1, ex_funct3=000, ex_in1=5, ex_in2=3.
3. Send addi x1,x0,-1 (0xFFF00093) -> ex_in1=0x00, ex_in2=0xFF, ex_modifier=0. Then send srai x2,x1,1 (0x4010D113):
   - instr_ready=0 while busy[1].
   - In the cycle wb_en=1, wb_rd=1, wb_data=0xFF, instr_ready=1. Expect ex_in1=0xFF (bypass), ex_in2=1, ex_funct3=101, ex_modifier=1.
4. Backpressure: hold ex_ready=0 for 3 cycles with a request pending -> instr_ready=0 and ex_* stable. Release ex_ready -> next instruction issued the following cycle.
5. Send opcode 0000011 -> no ex_valid for it; illegal=1 next cycle; instr_ready stays 0. Assert rst_n=0 -> illegal=0, ex_valid=0, FSM=RUN, scoreboard cleared.
6. Simultaneous set/clear: issue addi x4,x0,7 while wb_en=1, wb_rd=4 -> busy[4]=1 after the edge; register 4 = wb_data.
